// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ valid/ready requesters.
// Grants last up to MAX_BURST words or until the grantee drops valid; never writes while full.

module fifo_write_arbiter_lane #(
  parameter int WIDTH = 8
) (
  input  logic             sel,
  input  logic             valid,
  input  logic             full,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             wr,
  output logic [WIDTH-1:0] data_sel
);
  assign ready    = sel & ~full;
  assign wr       = sel & valid & ~full;
  // Non-selected lanes contribute zero so the top can OR-reduce the write bus.
  assign data_sel = sel ? data : '0;
endmodule

module fifo_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  localparam int IDXW     = $clog2(N_REQ),
  localparam int CNTW     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic                   clk,
  input  logic                   nrst_in,
  input  logic [N_REQ-1:0]       req_valid_in,
  input  logic [N_REQ*WIDTH-1:0] req_data_in,
  output logic [N_REQ-1:0]       req_ready_out,
  input  logic                   full_in,
  output logic                   write_out,
  output logic [WIDTH-1:0]       data_write_out,
  output logic [N_REQ-1:0]       grant_out,
  output logic [IDXW-1:0]        grant_idx_out,
  output logic                   busy_out
);

  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
    $error("fifo_write_arbiter: N_REQ must be 2..16");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("fifo_write_arbiter: WIDTH must be >= 1");
  end
  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
    $error("fifo_write_arbiter: MAX_BURST must be 1..255");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   g_q, g_d;
  logic [IDXW-1:0]   last_g_q, last_g_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]  grant_q, grant_d;

  logic [IDXW-1:0]   base;
  logic [IDXW-1:0]   pick_idx;
  logic              pick_vld;
  logic              valid_g;
  logic              xfer;
  logic              burst_last;

  logic [N_REQ-1:0]             lane_wr;
  logic [N_REQ-1:0][WIDTH-1:0]  lane_data;
  logic [WIDTH-1:0]             data_or;

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    fifo_write_arbiter_lane #(.WIDTH(WIDTH)) u_lane (
      .sel      (grant_q[i]),
      .valid    (req_valid_in[i]),
      .full     (full_in),
      .data     (req_data_in[i*WIDTH +: WIDTH]),
      .ready    (req_ready_out[i]),
      .wr       (lane_wr[i]),
      .data_sel (lane_data[i])
    );
  end

  always_comb begin
    data_or = '0;
    for (int i = 0; i < N_REQ; i++) data_or = data_or | lane_data[i];
  end

  assign write_out      = |lane_wr;
  assign data_write_out = data_or;
  assign grant_out      = grant_q;
  assign grant_idx_out  = g_q;
  assign busy_out       = (state_q == GRANT);

  // Search starts after the current grantee in GRANT (it becomes last_g on release),
  // otherwise after last_g; the base itself is the final candidate.
  assign base = (state_q == GRANT) ? g_q : last_g_q;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      int idx;
      idx = (int'(base) + k) % N_REQ;
      if (req_valid_in[idx]) begin
        pick_vld = 1'b1;
        pick_idx = IDXW'(idx);
      end
    end
  end

  assign valid_g    = req_valid_in[g_q];
  assign xfer       = (state_q == GRANT) & valid_g & ~full_in;
  assign burst_last = (cnt_q == CNTW'(MAX_BURST - 1));

  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    last_g_d = last_g_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = GRANT;
          g_d     = pick_idx;
          grant_d = N_REQ'(1) << pick_idx;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (xfer) cnt_d = cnt_q + CNTW'(1);
        // Release on a full burst or when the grantee withdraws, even while full.
        if ((xfer && burst_last) || !valid_g) begin
          last_g_d = g_q;
          cnt_d    = '0;
          if (pick_vld) begin
            g_d     = pick_idx;
            grant_d = N_REQ'(1) << pick_idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst_in) begin
    if (!nrst_in) begin
      state_q  <= IDLE;
      g_q      <= '0;
      last_g_q <= IDXW'(N_REQ - 1);
      cnt_q    <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      last_g_q <= last_g_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized bench for fifo_write_arbiter: cycle-level reference model plus a write scoreboard.

module tb_fifo_write_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;
  localparam int IW = $clog2(N);

  logic            clk = 1'b0;
  logic            nrst_in;
  logic [N-1:0]    req_valid_in;
  logic [N*W-1:0]  req_data_in;
  logic [N-1:0]    req_ready_out;
  logic            full_in;
  logic            write_out;
  logic [W-1:0]    data_write_out;
  logic [N-1:0]    grant_out;
  logic [IW-1:0]   grant_idx_out;
  logic            busy_out;

  fifo_write_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk            (clk),
    .nrst_in        (nrst_in),
    .req_valid_in   (req_valid_in),
    .req_data_in    (req_data_in),
    .req_ready_out  (req_ready_out),
    .full_in        (full_in),
    .write_out      (write_out),
    .data_write_out (data_write_out),
    .grant_out      (grant_out),
    .grant_idx_out  (grant_idx_out),
    .busy_out       (busy_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // requester drivers
  logic         cur_valid [N];
  logic [W-1:0] cur_data  [N];

  // reference model
  bit m_busy;
  int m_g, m_last, m_cnt;
  logic [W-1:0] exp_q[$];
  int rec[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int from);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (from + k) % N;
      if (cur_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_g    = 0;
    m_last = N - 1;
    m_cnt  = 0;
    exp_q.delete();
  endtask

  task automatic step(input logic [N-1:0] allow, input int p_on, input int p_drop, input int p_full);
    logic [N-1:0] mready;
    logic [N-1:0] mgrant;
    bit mwrite, xfer, rel;
    int p;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (!allow[i]) cur_valid[i] = 1'b0;
      else if (!cur_valid[i]) begin
        if ($urandom_range(99) < p_on) begin
          cur_valid[i] = 1'b1;
          cur_data[i]  = W'($urandom);
        end
      end else if ($urandom_range(99) < p_drop) cur_valid[i] = 1'b0;
    end
    full_in = ($urandom_range(99) < p_full);
    for (int i = 0; i < N; i++) begin
      req_valid_in[i]          = cur_valid[i];
      req_data_in[i*W +: W]    = cur_data[i];
    end
    #1;
    mgrant = m_busy ? N'(1) << m_g : '0;
    mready = (m_busy && !full_in) ? mgrant : '0;
    mwrite = m_busy && cur_valid[m_g] && !full_in;
    chk("grant_out", int'(grant_out), int'(mgrant));
    chk("grant_idx", int'(grant_idx_out), m_g);
    chk("busy", int'(busy_out), int'(m_busy));
    chk("ready", int'(req_ready_out), int'(mready));
    chk("write", int'(write_out), int'(mwrite));
    if (mwrite) exp_q.push_back(cur_data[m_g]);
    // state at the coming edge
    xfer = mwrite;
    if (m_busy) begin
      rel = !cur_valid[m_g] || (xfer && m_cnt == MB - 1);
      if (xfer) m_cnt++;
      if (rel) begin
        m_last = m_g;
        m_cnt  = 0;
        p = rr_pick(m_g);
        if (p >= 0) m_g = p;
        else m_busy = 1'b0;
      end
    end else begin
      p = rr_pick(m_last);
      if (p >= 0) begin
        m_busy = 1'b1;
        m_g    = p;
        m_cnt  = 0;
      end
    end
    for (int i = 0; i < N; i++)
      if (cur_valid[i] && mready[i]) cur_valid[i] = 1'b0;
  endtask

  // scoreboard monitor: every FIFO write must be the next expected word
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (nrst_in === 1'b1 && write_out === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fifo_data: unexpected write %0h with empty scoreboard at %0t", data_write_out, $time);
        end else begin
          e = exp_q.pop_front();
          chk("fifo_data", int'(data_write_out), int'(e));
        end
      end
    end
  end

  initial begin
    int n;
    int exp_seq [5];
    exp_seq = '{0, 1, 2, 3, 0};
    nrst_in      = 1'b0;
    full_in      = 1'b0;
    req_valid_in = '0;
    req_data_in  = '0;
    for (int i = 0; i < N; i++) begin
      cur_valid[i] = 1'b0;
      cur_data[i]  = '0;
    end
    model_reset();
    #1;
    chk("rst_grant", int'(grant_out), 0);
    chk("rst_write", int'(write_out), 0);
    chk("rst_ready", int'(req_ready_out), 0);
    chk("rst_busy", int'(busy_out), 0);
    chk("rst_idx", int'(grant_idx_out), 0);
    repeat (2) @(posedge clk);
    #2 nrst_in = 1'b1;

    // all requesters continuously valid: 0,1,2,3,0 with full bursts
    for (int c = 0; c < 20; c++) begin
      step(4'b1111, 100, 0, 0);
      #5;
      if (busy_out && (rec.size() == 0 || rec[$] != int'(grant_idx_out)))
        rec.push_back(int'(grant_idx_out));
    end
    chk("contention_len", (rec.size() >= 5) ? 1 : 0, 1);
    for (int k = 0; k < 5 && k < rec.size(); k++) chk("contention_seq", rec[k], exp_seq[k]);

    // single requester, continuous, spans burst re-grant
    for (int c = 0; c < 12; c++) step(4'b0010, 100, 0, 0);

    // random traffic with backpressure and early releases
    for (int c = 0; c < 2000; c++) step(4'b1111, 50, 12, 25);
    // heavy full with frequent drops
    for (int c = 0; c < 400; c++) step(4'b1111, 70, 30, 70);

    // async reset in the middle of a requester-0 burst
    n = 0;
    while (!(m_busy && m_g == 0 && m_cnt >= 1) && n < 40) begin
      step(4'b0001, 100, 0, 0);
      n++;
    end
    chk("reach_burst0", (n < 40) ? 1 : 0, 1);
    #2 nrst_in = 1'b0;
    #1;
    chk("midrst_grant", int'(grant_out), 0);
    chk("midrst_write", int'(write_out), 0);
    chk("midrst_ready", int'(req_ready_out), 0);
    chk("midrst_busy", int'(busy_out), 0);
    model_reset();
    @(posedge clk);
    #2 nrst_in = 1'b1;
    step(4'b0101, 100, 0, 0);
    #5;
    chk("post_rst_idx", int'(grant_idx_out), 0);
    chk("post_rst_grant", int'(grant_out), 1);
    for (int c = 0; c < 30; c++) step(4'b0101, 80, 10, 20);

    // drain to idle
    for (int c = 0; c < 6; c++) step(4'b0000, 0, 0, 0);
    #3;
    chk("drain_busy", int'(busy_out), 0);
    chk("drain_queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
